// File: rtl/wbl_write_seq.sv
// wbl_write_seq
//   Write-side sequencer for the DRAM-CIM AES key array. A start request
//   latches a 128-bit key and presents it to wbl_key_gen. The block then
//   steps the row address from 0 to NUM_ROWS-1. For each row it waits
//   SETTLE_CYC cycles, captures the generator's 16 WBL words and writes them
//   into the array using a we/ack handshake.
//
//   Optional feature: define WBL_SIG_EN to build an XOR signature of every
//   row that is written. Without the macro, sig is tied to 0.
//
// Ports
//   clk, rst     rising-edge clock; synchronous active-high reset
//   start        begin a sweep (sampled only in IDLE)
//   abort        cancel a sweep in progress (SETUP/WRITE only)
//   key_in       AES-128 key, latched when start is accepted
//   busy         high while in SETUP or WRITE
//   done         one-cycle pulse after the last row is acked
//   gen_key      latched key -> wbl_key_gen Kin
//   gen_addr     current row -> wbl_key_gen addr
//   gen_wbl      {WBL16..WBL1} from wbl_key_gen, WBL1 in the LSBs
//   arr_we       array write request (registered)
//   arr_row      row being written
//   arr_data     captured row data, same packing as gen_wbl
//   arr_ack      array accepts the write in any cycle with arr_we=1
//   sig          XOR signature of the written words (0 without WBL_SIG_EN)
module wbl_write_seq #(
  parameter int NUM_ROWS   = 64,
  parameter int ADDR_W     = 6,
  parameter int WORD_W     = 64,
  parameter int NUM_WBL    = 16,
  parameter int SETTLE_CYC = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [127:0]              key_in,
  output logic                      busy,
  output logic                      done,
  output logic [127:0]              gen_key,
  output logic [ADDR_W-1:0]         gen_addr,
  input  logic [NUM_WBL*WORD_W-1:0] gen_wbl,
  output logic                      arr_we,
  output logic [ADDR_W-1:0]         arr_row,
  output logic [NUM_WBL*WORD_W-1:0] arr_data,
  input  logic                      arr_ack,
  output logic [WORD_W-1:0]         sig
);

  localparam int DATA_W = NUM_WBL * WORD_W;
  localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

  state_t              state_reg, state_next;
  logic [127:0]        key_reg, key_next;
  logic [ADDR_W-1:0]   row_reg, row_next;
  logic [SET_W-1:0]    settle_reg, settle_next;
  logic [ADDR_W-1:0]   arr_row_reg, arr_row_next;
  logic [DATA_W-1:0]   arr_data_reg, arr_data_next;
  logic                arr_we_reg, busy_reg, done_reg;
  logic                start_fire, ack_fire;

  always_comb begin
    state_next    = state_reg;
    key_next      = key_reg;
    row_next      = row_reg;
    settle_next   = settle_reg;
    arr_row_next  = arr_row_reg;
    arr_data_next = arr_data_reg;
    start_fire    = 1'b0;
    ack_fire      = 1'b0;
    case (state_reg)
      IDLE: begin
        // start wins over a simultaneous abort: abort means nothing in IDLE
        if (start) begin
          start_fire  = 1'b1;
          key_next    = key_in;
          row_next    = '0;
          settle_next = '0;
          state_next  = SETUP;
        end
      end
      SETUP: begin
        if (abort) begin
          state_next = IDLE;
        end else if (settle_reg == SET_W'(SETTLE_CYC - 1)) begin
          arr_data_next = gen_wbl;
          arr_row_next  = row_reg;
          state_next    = WRITE;
        end else begin
          settle_next = settle_reg + SET_W'(1);
        end
      end
      WRITE: begin
        // arr_we is always high in WRITE, so any sampled ack completes the
        // write, even when abort arrives in the same cycle
        ack_fire = arr_ack;
        if (abort) begin
          state_next = IDLE;
        end else if (arr_ack) begin
          if (row_reg == ADDR_W'(NUM_ROWS - 1)) begin
            state_next = DONE;
          end else begin
            row_next    = row_reg + ADDR_W'(1);
            settle_next = '0;
            state_next  = SETUP;
          end
        end
      end
      default: state_next = IDLE;  // DONE lasts exactly one cycle
    endcase
  end

  // Status outputs are registered from the next state, so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      key_reg      <= '0;
      row_reg      <= '0;
      settle_reg   <= '0;
      arr_row_reg  <= '0;
      arr_data_reg <= '0;
      arr_we_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      key_reg      <= key_next;
      row_reg      <= row_next;
      settle_reg   <= settle_next;
      arr_row_reg  <= arr_row_next;
      arr_data_reg <= arr_data_next;
      arr_we_reg   <= (state_next == WRITE);
      busy_reg     <= (state_next == SETUP) || (state_next == WRITE);
      done_reg     <= (state_next == DONE);
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign gen_key  = key_reg;
  assign gen_addr = row_reg;
  assign arr_we   = arr_we_reg;
  assign arr_row  = arr_row_reg;
  assign arr_data = arr_data_reg;

`ifdef WBL_SIG_EN
  // XOR-fold the NUM_WBL words of the held row into a single word
  logic [WORD_W-1:0] fold [NUM_WBL+1];
  logic [WORD_W-1:0] sig_reg;

  assign fold[0] = '0;
  for (genvar gi = 0; gi < NUM_WBL; gi++) begin : g_fold
    assign fold[gi+1] = fold[gi] ^ arr_data_reg[gi*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk) begin
    if (rst || start_fire) begin
      sig_reg <= '0;
    end else if (ack_fire) begin
      sig_reg <= sig_reg ^ fold[NUM_WBL];
    end
  end

  assign sig = sig_reg;
`else
  logic unused_sig;
  assign unused_sig = start_fire ^ ack_fire;
  assign sig        = '0;
`endif

endmodule

// File: tb/tb_wbl_write_seq.sv
module tb_wbl_write_seq;

  localparam int NUM_ROWS = 64;
  localparam int ADDR_W   = 6;
  localparam int WORD_W   = 64;
  localparam int NUM_WBL  = 16;
  localparam int DATA_W   = NUM_WBL * WORD_W;

  logic              clk = 1'b0;
  logic              rst, start, abort, arr_ack;
  logic [127:0]      key_in, gen_key;
  logic              busy, done, arr_we;
  logic [ADDR_W-1:0] gen_addr, arr_row;
  logic [DATA_W-1:0] gen_wbl, arr_data;
  logic [WORD_W-1:0] sig;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stand-in for the wbl_key_gen ROM: distinct words per (key, row, index)
  function automatic logic [DATA_W-1:0] model(input logic [127:0] k, input int row);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < NUM_WBL; i++)
      r[i*WORD_W +: WORD_W] = k[63:0] ^ k[127:64] ^
                              (64'h9E3779B97F4A7C15 * 64'(row * NUM_WBL + i + 1));
    return r;
  endfunction

  always_comb gen_wbl = model(gen_key, int'(gen_addr));

  wbl_write_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .key_in(key_in),
    .busy(busy), .done(done), .gen_key(gen_key), .gen_addr(gen_addr),
    .gen_wbl(gen_wbl), .arr_we(arr_we), .arr_row(arr_row), .arr_data(arr_data),
    .arr_ack(arr_ack), .sig(sig)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a sweep and follows it to completion. Cycle 1 is the cycle after
  // the start edge. Returns write count, cycles on the stalled row, done info.
  task automatic run_sweep(input logic [127:0] key, input int stall_row, input int stall_len,
                           input int poke_row, input logic [127:0] poke_key,
                           output int we_cnt, output int stall_we, output int done_cyc,
                           output int done_cnt, output logic [WORD_W-1:0] sig_done);
    int exp_row, stalled, post, cyc;
    bit poked;
    we_cnt = 0; stall_we = 0; done_cyc = -1; done_cnt = 0; sig_done = '0;
    exp_row = 0; stalled = 0; post = 0; poked = 0;
    key_in = key; start = 1'b1; arr_ack = 1'b1;
    step();
    start = 1'b0; key_in = ~key;
    cyc = 1;
    for (int k = 0; k < 400 && post < 3; k++) begin
      if (busy && !arr_we) begin
        checks++;
        if (gen_addr !== ADDR_W'(exp_row)) begin
          failures++;
          $display("FAIL sweep_gen_addr cyc=%0d got=%0d exp=%0d", cyc, gen_addr, exp_row);
        end
      end
      if (arr_we) begin
        we_cnt++;
        if (exp_row == stall_row) stall_we++;
        checks++;
        if (arr_row !== ADDR_W'(exp_row) || arr_data !== model(key, exp_row)) begin
          failures++;
          $display("FAIL sweep_row cyc=%0d row got=%0d exp=%0d data_ok=%0b", cyc, arr_row,
                   exp_row, arr_data === model(key, exp_row));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        sig_done = sig;
      end
      if (done_cyc >= 0) post++;
      // next-cycle stimulus
      if (arr_we && exp_row == stall_row && stalled < stall_len) begin
        arr_ack = 1'b0;
        stalled++;
      end else begin
        arr_ack = 1'b1;
      end
      if (arr_we && exp_row == poke_row && !poked) begin
        start = 1'b1; key_in = poke_key; poked = 1;
      end else begin
        start = 1'b0;
      end
      if (arr_we && arr_ack) exp_row++;
      step();
      cyc++;
    end
    start = 1'b0; arr_ack = 1'b1;
    checks++;
    if (done_cyc < 0) begin
      failures++;
      $display("FAIL sweep_timeout got=no_done exp=done");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; arr_ack = 1'b1; key_in = '1;
    step(); step();
    checks++;
    if ({busy, done, arr_we} !== 3'b000 || gen_key !== '0 || gen_addr !== '0 ||
        arr_row !== '0 || arr_data !== '0 || sig !== '0) begin
      failures++;
      $display("FAIL reset_state got busy=%0b done=%0b we=%0b key=%h exp all zero",
               busy, done, arr_we, gen_key);
    end
    rst = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_full_sweep();
    int we_cnt, stall_we, done_cyc, done_cnt;
    logic [WORD_W-1:0] s;
    run_sweep(128'h0, -1, 0, -1, '0, we_cnt, stall_we, done_cyc, done_cnt, s);
    checks++;
    if (we_cnt !== 64) begin
      failures++; $display("FAIL full_we_count got=%0d exp=64", we_cnt);
    end
    checks++;
    if (done_cyc !== 129 || done_cnt !== 1) begin
      failures++; $display("FAIL full_done got cyc=%0d cnt=%0d exp cyc=129 cnt=1", done_cyc, done_cnt);
    end
    checks++;
    if (gen_key !== 128'h0) begin
      failures++; $display("FAIL full_gen_key got=%h exp=0", gen_key);
    end
    $display("test_full_sweep we=%0d done_cyc=%0d", we_cnt, done_cyc);
  endtask

  task automatic test_ack_stall();
    int we_cnt, stall_we, done_cyc, done_cnt;
    logic [WORD_W-1:0] s;
    run_sweep(128'h000102030405060708090a0b0c0d0e0f, 5, 3, -1, '0,
              we_cnt, stall_we, done_cyc, done_cnt, s);
    checks++;
    if (stall_we !== 4) begin
      failures++; $display("FAIL stall_hold got=%0d exp=4", stall_we);
    end
    checks++;
    if (done_cyc !== 132 || done_cnt !== 1) begin
      failures++; $display("FAIL stall_done got cyc=%0d cnt=%0d exp cyc=132 cnt=1", done_cyc, done_cnt);
    end
    checks++;
    if (we_cnt !== 67) begin
      failures++; $display("FAIL stall_we_count got=%0d exp=67", we_cnt);
    end
    $display("test_ack_stall hold=%0d done_cyc=%0d", stall_we, done_cyc);
  endtask

  task automatic test_start_ignored();
    int we_cnt, stall_we, done_cyc, done_cnt;
    logic [WORD_W-1:0] s;
    run_sweep(128'h0123456789abcdef_fedcba9876543210, -1, 0, 20,
              128'hdeadbeefdeadbeef_cafef00dcafef00d, we_cnt, stall_we, done_cyc, done_cnt, s);
    checks++;
    if (gen_key !== 128'h0123456789abcdef_fedcba9876543210) begin
      failures++; $display("FAIL busy_start_key got=%h exp=0123456789abcdeffedcba9876543210", gen_key);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 129 || we_cnt !== 64) begin
      failures++;
      $display("FAIL busy_start_sweep got done_cnt=%0d cyc=%0d we=%0d exp 1/129/64",
               done_cnt, done_cyc, we_cnt);
    end
    $display("test_start_ignored done_cnt=%0d", done_cnt);
  endtask

  task automatic test_abort();
    bit hit = 0;
    key_in = 128'h11; start = 1'b1; arr_ack = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      if (arr_we && arr_row == 10) begin
        hit = 1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({busy, arr_we, done} !== 3'b000) begin
          failures++;
          $display("FAIL abort_next got busy=%0b we=%0b done=%0b exp 0/0/0", busy, arr_we, done);
        end
      end else begin
        step();
      end
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL abort_reach got=no_row10 exp=row10");
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL abort_idle got done=%0b busy=%0b exp 0/0", done, busy);
      end
    end
    key_in = 128'h22; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || gen_addr !== '0 || gen_key !== 128'h22) begin
      failures++;
      $display("FAIL abort_restart got busy=%0b addr=%0d key=%h exp 1/0/22", busy, gen_addr, gen_key);
    end
    step();
    checks++;
    if (arr_we !== 1'b1 || arr_row !== '0 || arr_data !== model(128'h22, 0)) begin
      failures++; $display("FAIL abort_row0 got we=%0b row=%0d exp 1/0", arr_we, arr_row);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    $display("test_abort restarted_row=%0d", 0);
  endtask

  task automatic test_rst_mid();
    bit hit = 0;
    key_in = 128'h33; start = 1'b1; arr_ack = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      if (busy && !arr_we && gen_addr == 33) begin
        hit = 1;
        rst = 1'b1;
        step();
        checks++;
        if ({busy, done, arr_we} !== 3'b000 || gen_key !== '0 || gen_addr !== '0 ||
            arr_row !== '0 || arr_data !== '0 || sig !== '0) begin
          failures++;
          $display("FAIL rst_mid got busy=%0b we=%0b addr=%0d row=%0d key=%h exp all zero",
                   busy, arr_we, gen_addr, arr_row, gen_key);
        end
        rst = 1'b0;
      end else begin
        step();
      end
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL rst_reach got=no_row33 exp=row33");
    end
    step(); step();
    checks++;
    if (busy !== 1'b0 || arr_we !== 1'b0) begin
      failures++; $display("FAIL rst_idle got busy=%0b we=%0b exp 0/0", busy, arr_we);
    end
    $display("test_rst_mid hit=%0b", hit);
  endtask

  task automatic test_signature();
    int we_cnt, stall_we, done_cyc, done_cnt;
    logic [WORD_W-1:0] s, exp_sig;
    logic [DATA_W-1:0] row_data;
    exp_sig = '0;
`ifdef WBL_SIG_EN
    for (int r = 0; r < NUM_ROWS; r++) begin
      row_data = model(128'h0, r);
      for (int i = 0; i < NUM_WBL; i++) exp_sig ^= row_data[i*WORD_W +: WORD_W];
    end
`else
    row_data = '0;
`endif
    run_sweep(128'h0, -1, 0, -1, '0, we_cnt, stall_we, done_cyc, done_cnt, s);
    checks++;
    if (s !== exp_sig) begin
      failures++; $display("FAIL sig_at_done got=%h exp=%h", s, exp_sig);
    end
    checks++;
    if (sig !== exp_sig) begin
      failures++; $display("FAIL sig_hold got=%h exp=%h", sig, exp_sig);
    end
    $display("test_signature sig=%h", s);
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_ack_stall();
    test_start_ignored();
    test_abort();
    test_rst_mid();
    test_signature();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
